// File: rtl/iosys_pkg.sv
// rtl/iosys_pkg.sv - shared types and constants for the iosys SDRAM arbiter
package iosys_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LO,
        ST_HI,
        ST_WAIT,
        ST_DONE
    } arb_state_t;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_P0,
        GNT_P1
    } grant_t;

    localparam logic [31:0] ADDR_LIMIT_DEFAULT = 32'h0080_0000;
    localparam int          RD_LAT_DEFAULT     = 2;

    // Half tags travelling with read strobes, and the matching SDRAM address offsets
    localparam logic       HALF_LO   = 1'b0;
    localparam logic       HALF_HI   = 1'b1;
    localparam logic [1:0] LO_OFFSET = 2'b00;
    localparam logic [1:0] HI_OFFSET = 2'b10;

endpackage

// File: rtl/iosys_rd_pipe.sv
// rtl/iosys_rd_pipe.sv - delays read strobes by RD_LAT cycles into lo/hi sample enables
module iosys_rd_pipe
    import iosys_pkg::*;
#(
    parameter int RD_LAT = RD_LAT_DEFAULT
) (
    input  logic wclk,
    input  logic resetn,
    input  logic rd_strobe,
    input  logic rd_half,
    output logic sample_lo,
    output logic sample_hi
);

    logic [RD_LAT-1:0] vld_sr;
    logic [RD_LAT-1:0] half_sr;

    always_ff @(posedge wclk or negedge resetn) begin
        if (!resetn) begin
            vld_sr  <= '0;
            half_sr <= '0;
        end else begin
            vld_sr[0]  <= rd_strobe;
            half_sr[0] <= rd_half;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_sr[i]  <= vld_sr[i-1];
                half_sr[i] <= half_sr[i-1];
            end
        end
    end

    assign sample_lo = vld_sr[RD_LAT-1] && (half_sr[RD_LAT-1] == HALF_LO);
    assign sample_hi = vld_sr[RD_LAT-1] && (half_sr[RD_LAT-1] != HALF_LO);

endmodule

// File: rtl/iosys_mem_arbiter.sv
// rtl/iosys_mem_arbiter.sv - two-port 32-bit to 16-bit SDRAM arbiter, port 0 has priority
module iosys_mem_arbiter
    import iosys_pkg::*;
#(
    parameter int          RD_LAT     = RD_LAT_DEFAULT,
    parameter logic [31:0] ADDR_LIMIT = ADDR_LIMIT_DEFAULT
) (
    input  logic        wclk,
    input  logic        resetn,
    input  logic        ram_busy,
    input  logic        p0_valid,
    input  logic [31:0] p0_addr,
    input  logic [3:0]  p0_wstrb,
    input  logic [31:0] p0_wdata,
    output logic [31:0] p0_rdata,
    output logic        p0_ready,
    input  logic        p1_valid,
    input  logic [31:0] p1_addr,
    input  logic [3:0]  p1_wstrb,
    input  logic [31:0] p1_wdata,
    output logic [31:0] p1_rdata,
    output logic        p1_ready,
    output logic [22:0] rv_addr,
    output logic [15:0] rv_din,
    output logic [1:0]  rv_ds,
    output logic        rv_rd,
    output logic        rv_wr,
    input  logic [15:0] rv_dout
);

    arb_state_t  state, state_nxt;
    grant_t      grant_q;
    logic [22:2] addr_q;
    logic [3:0]  wstrb_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic [31:0] req_addr;
    logic        take;
    logic        oor;
    logic        is_rd;
    logic        rd_half;
    logic        sample_lo;
    logic        sample_hi;

    assign req_addr = p0_valid ? p0_addr : p1_addr;
    assign oor      = (req_addr >= ADDR_LIMIT);
    assign is_rd    = (wstrb_q == 4'b0000);
    assign rd_half  = (state == ST_HI) ? HALF_HI : HALF_LO;

    always_ff @(posedge wclk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Strobes are gated by ram_busy combinationally so a busy cycle can never carry one
    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        rv_addr   = '0;
        rv_din    = '0;
        rv_ds     = '0;
        rv_rd     = 1'b0;
        rv_wr     = 1'b0;
        p0_ready  = 1'b0;
        p1_ready  = 1'b0;
        p0_rdata  = '0;
        p1_rdata  = '0;
        case (state)
            ST_IDLE: begin
                if (!ram_busy && (p0_valid || p1_valid)) begin
                    take      = 1'b1;
                    state_nxt = oor ? ST_DONE : ST_LO;
                end
            end
            ST_LO: begin
                rv_addr = {addr_q, LO_OFFSET};
                rv_din  = wdata_q[15:0];
                rv_ds   = wstrb_q[1:0];
                if (!ram_busy) begin
                    rv_rd     = is_rd;
                    rv_wr     = |wstrb_q[1:0];
                    state_nxt = ST_HI;
                end
            end
            ST_HI: begin
                rv_addr = {addr_q, HI_OFFSET};
                rv_din  = wdata_q[31:16];
                rv_ds   = wstrb_q[3:2];
                if (!ram_busy) begin
                    rv_rd     = is_rd;
                    rv_wr     = |wstrb_q[3:2];
                    state_nxt = is_rd ? ST_WAIT : ST_DONE;
                end
            end
            ST_WAIT: begin
                if (sample_hi) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                p0_ready  = (grant_q == GNT_P0);
                p1_ready  = (grant_q == GNT_P1);
                p0_rdata  = (grant_q == GNT_P0) ? rdata_q : '0;
                p1_rdata  = (grant_q == GNT_P1) ? rdata_q : '0;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // rdata is cleared at grant so writes and out-of-range accesses return zero
    always_ff @(posedge wclk or negedge resetn) begin
        if (!resetn) begin
            grant_q <= GNT_NONE;
            addr_q  <= '0;
            wstrb_q <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            if (take) begin
                grant_q <= p0_valid ? GNT_P0 : GNT_P1;
                addr_q  <= req_addr[22:2];
                wstrb_q <= p0_valid ? p0_wstrb : p1_wstrb;
                wdata_q <= p0_valid ? p0_wdata : p1_wdata;
                rdata_q <= '0;
            end else if (state == ST_DONE) begin
                grant_q <= GNT_NONE;
            end
            if (sample_lo) begin
                rdata_q[15:0] <= rv_dout;
            end
            if (sample_hi) begin
                rdata_q[31:16] <= rv_dout;
            end
        end
    end

    iosys_rd_pipe #(
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .wclk      (wclk),
        .resetn    (resetn),
        .rd_strobe (rv_rd),
        .rd_half   (rd_half),
        .sample_lo (sample_lo),
        .sample_hi (sample_hi)
    );

endmodule

// File: tb/tb_iosys_mem_arbiter.sv
// tb/tb_iosys_mem_arbiter.sv - self-checking bench for iosys_mem_arbiter
module tb_iosys_mem_arbiter;

    localparam int          RD_LAT = 2;
    localparam logic [31:0] LIMIT  = 32'h0080_0000;

    logic        wclk = 1'b0;
    logic        resetn;
    logic        ram_busy;
    logic        p0_valid, p1_valid;
    logic [31:0] p0_addr, p1_addr;
    logic [3:0]  p0_wstrb, p1_wstrb;
    logic [31:0] p0_wdata, p1_wdata;
    logic [31:0] p0_rdata, p1_rdata;
    logic        p0_ready, p1_ready;
    logic [22:0] rv_addr;
    logic [15:0] rv_din;
    logic [1:0]  rv_ds;
    logic        rv_rd, rv_wr;
    logic [15:0] rv_dout = 16'hF00D;

    iosys_mem_arbiter #(
        .RD_LAT     (RD_LAT),
        .ADDR_LIMIT (LIMIT)
    ) dut (
        .wclk     (wclk),
        .resetn   (resetn),
        .ram_busy (ram_busy),
        .p0_valid (p0_valid),
        .p0_addr  (p0_addr),
        .p0_wstrb (p0_wstrb),
        .p0_wdata (p0_wdata),
        .p0_rdata (p0_rdata),
        .p0_ready (p0_ready),
        .p1_valid (p1_valid),
        .p1_addr  (p1_addr),
        .p1_wstrb (p1_wstrb),
        .p1_wdata (p1_wdata),
        .p1_rdata (p1_rdata),
        .p1_ready (p1_ready),
        .rv_addr  (rv_addr),
        .rv_din   (rv_din),
        .rv_ds    (rv_ds),
        .rv_rd    (rv_rd),
        .rv_wr    (rv_wr),
        .rv_dout  (rv_dout)
    );

    always #5 wclk = ~wclk;

    typedef struct {
        bit          wr;
        logic [22:0] addr;
        logic [1:0]  ds;
        logic [15:0] din;
    } strb_t;

    typedef struct {
        int          port;
        logic [31:0] rdata;
    } ack_t;

    strb_t       exp_strb[$];
    ack_t        exp_ack[$];
    logic [7:0]  exp_byte[int];
    logic [15:0] sdram[int];
    logic [15:0] sched[int];
    int          cyc     = 0;
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    function automatic logic [7:0] mbyte(input int a);
        return exp_byte.exists(a) ? exp_byte[a] : 8'h00;
    endfunction

    function automatic int exp_lat(input logic [31:0] addr, input logic [3:0] wstrb);
        if (addr >= LIMIT) return 1;
        return (wstrb != 4'h0) ? 3 : 3 + RD_LAT;
    endfunction

    task automatic preload(input int addr, input logic [31:0] word);
        sdram[addr]     = word[15:0];
        sdram[addr + 2] = word[31:16];
        for (int b = 0; b < 4; b++) exp_byte[addr + b] = word[8*b +: 8];
    endtask

    // Transaction-level expectation: which SDRAM strobes appear and what the requester gets back
    task automatic model_req(input int port, input logic [31:0] addr, input logic [3:0] wstrb,
                             input logic [31:0] wdata, input bit acked);
        int          base;
        logic [31:0] rd;
        strb_t       s;
        ack_t        a;
        base = int'(addr & 32'hFFFF_FFFC);
        rd   = '0;
        if (addr < LIMIT) begin
            for (int h = 0; h < 2; h++) begin
                if (wstrb == 4'h0 || wstrb[2*h +: 2] != 2'b00) begin
                    s.wr   = (wstrb != 4'h0);
                    s.addr = 23'(base + 2*h);
                    s.ds   = wstrb[2*h +: 2];
                    s.din  = wdata[16*h +: 16];
                    exp_strb.push_back(s);
                end
            end
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) exp_byte[base + b] = wdata[8*b +: 8];
                else if (wstrb == 4'h0) rd[8*b +: 8] = mbyte(base + b);
            end
        end
        if (acked) begin
            a.port  = port;
            a.rdata = rd;
            exp_ack.push_back(a);
        end
    endtask

    always @(posedge wclk) begin
        cyc = cyc + 1;
        #1 rv_dout = sched.exists(cyc) ? sched[cyc] : 16'hF00D;
    end

    // SDRAM responder plus the per-cycle compare against the expectation queues
    always @(negedge wclk) begin
        strb_t       s;
        ack_t        a;
        logic [15:0] w;
        if (rv_rd || rv_wr) begin
            chk("rd_wr_exclusive", {31'd0, rv_rd & rv_wr}, 32'd0);
            chk("strobe_while_busy", {31'd0, ram_busy}, 32'd0);
            chk("strobe_expected", {31'd0, exp_strb.size() > 0}, 32'd1);
            if (exp_strb.size() > 0) begin
                s = exp_strb.pop_front();
                chk("strobe_is_write", {31'd0, rv_wr}, {31'd0, s.wr});
                chk("strobe_addr", {9'd0, rv_addr}, {9'd0, s.addr});
                chk("strobe_ds", {30'd0, rv_ds}, {30'd0, s.ds});
                if (s.wr) chk("strobe_din", {16'd0, rv_din}, {16'd0, s.din});
            end
            if (rv_wr) begin
                w = sdram.exists(int'(rv_addr)) ? sdram[int'(rv_addr)] : 16'h0;
                if (rv_ds[0]) w[7:0]  = rv_din[7:0];
                if (rv_ds[1]) w[15:8] = rv_din[15:8];
                sdram[int'(rv_addr)] = w;
            end
            if (rv_rd) begin
                sched[cyc + RD_LAT] = sdram.exists(int'(rv_addr)) ? sdram[int'(rv_addr)] : 16'h0;
            end
        end
        if (p0_ready || p1_ready) begin
            chk("ready_exclusive", {31'd0, p0_ready & p1_ready}, 32'd0);
            chk("ack_expected", {31'd0, exp_ack.size() > 0}, 32'd1);
            if (exp_ack.size() > 0) begin
                a = exp_ack.pop_front();
                chk("ack_port", p1_ready ? 32'd1 : 32'd0, a.port);
                chk("ack_rdata", p1_ready ? p1_rdata : p0_rdata, a.rdata);
            end
        end
    end

    task automatic drive(input int port, input logic v, input logic [31:0] addr,
                         input logic [3:0] wstrb, input logic [31:0] wdata);
        if (port == 0) begin
            p0_valid = v; p0_addr = addr; p0_wstrb = wstrb; p0_wdata = wdata;
        end else begin
            p1_valid = v; p1_addr = addr; p1_wstrb = wstrb; p1_wdata = wdata;
        end
    endtask

    task automatic do_req(input int port, input logic [31:0] addr, input logic [3:0] wstrb,
                          input logic [31:0] wdata, input int want_lat, output logic [31:0] rdata);
        int lat;
        bit got;
        lat   = 0;
        got   = 1'b0;
        rdata = '0;
        drive(port, 1'b1, addr, wstrb, wdata);
        while (!got && lat < 40) begin
            @(negedge wclk);
            if ((port == 0 && p0_ready) || (port == 1 && p1_ready)) begin
                got   = 1'b1;
                rdata = (port == 1) ? p1_rdata : p0_rdata;
            end else begin
                lat++;
            end
        end
        chk("ack_within_budget", {31'd0, got}, 32'd1);
        if (got) chk("ack_latency", lat, want_lat);
        @(posedge wclk);
        #1 drive(port, 1'b0, '0, '0, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000 ns");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd, rd0;
        int          nrdy;
        resetn   = 1'b0;
        ram_busy = 1'b0;
        drive(0, 1'b0, '0, '0, '0);
        drive(1, 1'b0, '0, '0, '0);
        preload(32'h100, 32'hABCD_1234);
        preload(32'h020, 32'h2222_1111);
        preload(32'h060, 32'h3333_4444);
        preload(32'h300, 32'h9ABC_5678);
        preload(32'h000, 32'hCAFE_F00D);
        preload(32'h7F_FFFC, 32'h0BAD_BEEF);

        chk("model_lat_read", exp_lat(32'h100, 4'h0), 5);
        chk("model_lat_write", exp_lat(32'h20, 4'h6), 3);
        chk("model_lat_oor", exp_lat(32'h0200_0000, 4'h0), 1);

        repeat (3) @(posedge wclk);
        @(negedge wclk);
        chk("rst_p0_ready", {31'd0, p0_ready}, 32'd0);
        chk("rst_p1_ready", {31'd0, p1_ready}, 32'd0);
        chk("rst_p0_rdata", p0_rdata, 32'd0);
        chk("rst_p1_rdata", p1_rdata, 32'd0);
        chk("rst_rv_rd_wr", {30'd0, rv_rd, rv_wr}, 32'd0);
        chk("rst_rv_addr", {9'd0, rv_addr}, 32'd0);
        chk("rst_rv_din_ds", {14'd0, rv_din, rv_ds}, 32'd0);
        @(posedge wclk);
        #1 resetn = 1'b1;
        @(posedge wclk);
        #1;

        model_req(1, 32'h100, 4'h0, 32'h0, 1'b1);
        do_req(1, 32'h100, 4'h0, 32'h0, exp_lat(32'h100, 4'h0), rd);
        chk("p1_read_0x100", rd, 32'hABCD_1234);

        model_req(1, 32'h20, 4'b0110, 32'hDEAD_BEEF, 1'b1);
        do_req(1, 32'h20, 4'b0110, 32'hDEAD_BEEF, exp_lat(32'h20, 4'b0110), rd);
        chk("p1_write_rdata", rd, 32'd0);
        model_req(1, 32'h20, 4'h0, 32'h0, 1'b1);
        do_req(1, 32'h20, 4'h0, 32'h0, 5, rd);
        chk("p1_readback_0x20", rd, 32'h22AD_BE11);

        model_req(0, 32'h60, 4'b1100, 32'hFFFF_FFFF, 1'b1);
        do_req(0, 32'h60, 4'b1100, 32'hFFFF_FFFF, 3, rd);
        model_req(0, 32'h60, 4'h0, 32'h0, 1'b1);
        do_req(0, 32'h60, 4'h0, 32'h0, 5, rd);
        chk("p0_readback_0x60", rd, 32'hFFFF_4444);

        model_req(0, 32'h40, 4'hF, 32'h1122_3344, 1'b1);
        model_req(1, 32'h40, 4'h0, 32'h0, 1'b1);
        fork
            do_req(0, 32'h40, 4'hF, 32'h1122_3344, 3, rd0);
            do_req(1, 32'h40, 4'h0, 32'h0, 9, rd);
        join
        chk("p0_first_write_rdata", rd0, 32'd0);
        chk("p1_after_p0_read", rd, 32'h1122_3344);

        model_req(1, 32'h0200_0000, 4'h0, 32'h0, 1'b1);
        do_req(1, 32'h0200_0000, 4'h0, 32'h0, exp_lat(32'h0200_0000, 4'h0), rd);
        chk("oor_read_rdata", rd, 32'd0);
        model_req(1, LIMIT, 4'hF, 32'hFFFF_FFFF, 1'b1);
        do_req(1, LIMIT, 4'hF, 32'hFFFF_FFFF, 1, rd);
        model_req(0, 32'h0, 4'h0, 32'h0, 1'b1);
        do_req(0, 32'h0, 4'h0, 32'h0, 5, rd);
        chk("no_alias_after_oor_write", rd, 32'hCAFE_F00D);
        model_req(1, 32'h7F_FFFC, 4'h0, 32'h0, 1'b1);
        do_req(1, 32'h7F_FFFC, 4'h0, 32'h0, 5, rd);
        chk("last_word_read", rd, 32'h0BAD_BEEF);

        model_req(1, 32'h300, 4'h0, 32'h0, 1'b1);
        fork
            do_req(1, 32'h300, 4'h0, 32'h0, 10, rd);
            begin
                repeat (2) @(posedge wclk);
                #1 ram_busy = 1'b1;
                repeat (5) @(posedge wclk);
                #1 ram_busy = 1'b0;
            end
        join
        chk("busy_stall_read", rd, 32'h9ABC_5678);

        model_req(1, 32'h100, 4'h0, 32'h0, 1'b0);
        drive(1, 1'b1, 32'h100, 4'h0, 32'h0);
        repeat (3) @(posedge wclk);
        #1 resetn = 1'b0;
        #1;
        chk("midrst_ready", {30'd0, p0_ready, p1_ready}, 32'd0);
        chk("midrst_rdata", p1_rdata | p0_rdata, 32'd0);
        chk("midrst_rv", {7'd0, rv_addr, rv_ds}, 32'd0);
        chk("midrst_strobes", {30'd0, rv_rd, rv_wr}, 32'd0);
        drive(1, 1'b0, '0, '0, '0);
        repeat (2) @(posedge wclk);
        #1 resetn = 1'b1;
        nrdy = 0;
        repeat (12) begin
            @(negedge wclk);
            nrdy += int'(p0_ready) + int'(p1_ready);
        end
        chk("no_ready_after_reset", nrdy, 0);

        chk("strobes_all_seen", exp_strb.size(), 0);
        chk("acks_all_seen", exp_ack.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
